// File: rtl/fetch_npc_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_npc_unit_pkg
//  Brief    : Shared next-PC encodings and reset address for the fetch stage
//             and the decode-stage controller.
//  Revision : 1.0  initial release
// ============================================================================
package fetch_npc_unit_pkg;

  // Decode-stage next-PC class driven by the controller
  typedef enum logic [1:0] {
    NPC_SEQ = 2'd0,
    NPC_BR  = 2'd1,
    NPC_J   = 2'd2,
    NPC_JR  = 2'd3
  } npc_op_e;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] INSTR_BYTES      = 32'd4;

  // Word offset of a branch: sign-extended 16-bit immediate times four
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage : fetch_npc_unit_pkg
`default_nettype wire

// File: rtl/fetch_npc_unit_npc.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_npc_unit_npc
//  Brief    : Combinational next-PC mux with branch / jump target adders.
//             Only the low 26 instruction bits participate in any target.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_npc_unit_npc
  import fetch_npc_unit_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [31:0] id_pc4_i,
  input  logic [25:0] id_instr_i,
  input  logic [1:0]  npc_op_i,
  input  logic        branch_i,
  input  logic [31:0] jr_target_i,
  output logic [31:0] next_pc_o,
  output logic        misalign_o
);

  logic [31:0] seq_pc;
  logic [31:0] br_pc;
  logic [31:0] j_pc;
  logic [31:0] jr_pc;

  assign seq_pc = pc_i + INSTR_BYTES;
  assign br_pc  = id_pc4_i + branch_offset(id_instr_i[15:0]);
  assign j_pc   = {id_pc4_i[31:28], id_instr_i[25:0], 2'b00};
  assign jr_pc  = {jr_target_i[31:2], 2'b00};

  // Select the fetch address for the next edge from the decode-stage class
  always_comb begin
    next_pc_o  = seq_pc;
    misalign_o = 1'b0;
    unique case (npc_op_e'(npc_op_i))
      NPC_SEQ: next_pc_o = seq_pc;
      NPC_BR:  next_pc_o = branch_i ? br_pc : seq_pc;
      NPC_J:   next_pc_o = j_pc;
      NPC_JR: begin
        next_pc_o  = jr_pc;
        misalign_o = |jr_target_i[1:0];
      end
      default: next_pc_o = seq_pc;
    endcase
  end

endmodule : fetch_npc_unit_npc
`default_nettype wire

// File: rtl/fetch_npc_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_npc_unit
//  Brief    : Fetch-stage PC register and IF/ID pipeline register with one
//             architectural delay slot (redirects never flush).
//  Revision : 1.0  initial release
// ============================================================================
module fetch_npc_unit
  import fetch_npc_unit_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT
)(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  npc_op,
  input  logic        branch,
  input  logic [31:0] jr_target,
  input  logic [31:0] if_instr,
  output logic [31:0] pc,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc4,
  output logic [31:0] id_pc8,
  output logic        id_valid,
  output logic        pc_misalign
);

  logic [31:0] pc_q,       pc_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc4_q,   id_pc4_d;
  logic        id_valid_q, id_valid_d;
  logic        misalign_q, misalign_d;

  logic [31:0] next_pc;
  logic        jr_misalign;

  fetch_npc_unit_npc u_npc (
    .pc_i        (pc_q),
    .id_pc4_i    (id_pc4_q),
    .id_instr_i  (id_instr_q[25:0]),
    .npc_op_i    (npc_op),
    .branch_i    (branch),
    .jr_target_i (jr_target),
    .next_pc_o   (next_pc),
    .misalign_o  (jr_misalign)
  );

  // Stall freezes everything; a held redirect is recomputed next unstalled edge
  always_comb begin
    pc_d       = pc_q;
    id_instr_d = id_instr_q;
    id_pc4_d   = id_pc4_q;
    id_valid_d = id_valid_q;
    misalign_d = misalign_q;
    if (!stall) begin
      pc_d       = next_pc;
      id_instr_d = if_instr;
      id_pc4_d   = pc_q + INSTR_BYTES;
      id_valid_d = 1'b1;
      misalign_d = misalign_q | jr_misalign;
    end
  end

  // PC, IF/ID and sticky misalign flag, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= PC_RESET;
      id_instr_q <= 32'd0;
      id_pc4_q   <= PC_RESET;
      id_valid_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      id_instr_q <= id_instr_d;
      id_pc4_q   <= id_pc4_d;
      id_valid_q <= id_valid_d;
      misalign_q <= misalign_d;
    end
  end

  assign pc          = pc_q;
  assign id_instr    = id_instr_q;
  assign id_pc4      = id_pc4_q;
  assign id_pc8      = id_pc4_q + INSTR_BYTES;
  assign id_valid    = id_valid_q;
  assign pc_misalign = misalign_q;

endmodule : fetch_npc_unit
`default_nettype wire

// File: tb/tb_fetch_npc_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_npc_unit
//  Brief    : Scoreboard bench for fetch_npc_unit with a behavioural PC model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_npc_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic [1:0]  npc_op = 2'd0;
  logic        branch = 1'b0;
  logic [31:0] jr_target = 32'd0;
  logic [31:0] if_instr = 32'd0;
  logic [31:0] pc, id_instr, id_pc4, id_pc8;
  logic        id_valid, pc_misalign;

  fetch_npc_unit dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .npc_op      (npc_op),
    .branch      (branch),
    .jr_target   (jr_target),
    .if_instr    (if_instr),
    .pc          (pc),
    .id_instr    (id_instr),
    .id_pc4      (id_pc4),
    .id_pc8      (id_pc8),
    .id_valid    (id_valid),
    .pc_misalign (pc_misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc, instr, pc4, pc8;
    logic        valid, mis;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;

  // Reference model state: the architectural view of the fetch stage
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid, m_mis;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_pc = 32'h0000_3000; m_instr = 32'd0; m_pc4 = 32'h0000_3000;
    m_valid = 1'b0; m_mis = 1'b0;
  endtask

  task automatic model_step(input logic st, input logic [1:0] op, input logic br,
                            input logic [31:0] jrt, input logic [31:0] ifi);
    logic [31:0] nxt;
    int          off;
    if (st) return;
    off = int'($signed(m_instr[15:0])) * 4;
    case (op)
      2'd1:    nxt = br ? m_pc4 + 32'(off) : m_pc + 32'd4;
      2'd2:    nxt = (m_pc4 & 32'hF000_0000) + (m_instr & 32'h03FF_FFFF) * 32'd4;
      2'd3: begin
        nxt = jrt - (jrt % 32'd4);
        if (jrt % 32'd4 != 0) m_mis = 1'b1;
      end
      default: nxt = m_pc + 32'd4;
    endcase
    m_pc4 = m_pc + 32'd4;
    m_instr = ifi;
    m_valid = 1'b1;
    m_pc = nxt;
  endtask

  task automatic push_exp();
    exp_t e;
    e.pc = m_pc; e.instr = m_instr; e.pc4 = m_pc4; e.pc8 = m_pc4 + 32'd4;
    e.valid = m_valid; e.mis = m_mis;
    exp_q.push_back(e);
  endtask

  // One clock of stimulus; the expected post-edge state goes to the scoreboard
  task automatic drive(input logic rst, input logic st, input logic [1:0] op, input logic br,
                       input logic [31:0] jrt, input logic [31:0] ifi);
    @(negedge clk);
    reset = rst; stall = st; npc_op = op; branch = br; jr_target = jrt; if_instr = ifi;
    if (rst) model_reset();
    else model_step(st, op, br, jrt, ifi);
    push_exp();
  endtask

  // Assert reset between edges; the monitor samples right after it rises
  task automatic async_reset();
    @(negedge clk);
    #2;
    model_reset();
    push_exp();
    reset = 1'b1;
    drive(1'b1, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
  endtask

  // Monitor: compare whenever the DUT state can change
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or posedge reset);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("pc",          pc,          e.pc);
        check("id_instr",    id_instr,    e.instr);
        check("id_pc4",      id_pc4,      e.pc4);
        check("id_pc8",      id_pc8,      e.pc8);
        check("id_valid",    {31'd0, id_valid},    {31'd0, e.valid});
        check("pc_misalign", {31'd0, pc_misalign}, {31'd0, e.mis});
      end
    end
  end

  initial begin
    model_reset();
    // Sequential fetch
    async_reset();
    for (int i = 0; i < 4; i++) drive(0, 0, 2'd0, 0, 32'd0, 32'h2400_0000 + i);

    // beq imm 3 at 0x3004: taken, then not taken; beq imm -2 at 0x300C
    async_reset();
    drive(0, 0, 2'd0, 0, 32'd0, 32'h0000_0000);
    drive(0, 0, 2'd0, 0, 32'd0, 32'h1000_0003);
    drive(0, 0, 2'd1, 1, 32'd0, 32'h2400_0011);   // delay slot, pc -> 0x3014
    async_reset();
    drive(0, 0, 2'd0, 0, 32'd0, 32'h0000_0000);
    drive(0, 0, 2'd0, 0, 32'd0, 32'h1000_0003);
    drive(0, 0, 2'd1, 0, 32'd0, 32'h2400_0012);   // not taken
    drive(0, 0, 2'd0, 0, 32'd0, 32'h1000_FFFE);   // word at 0x300C
    drive(0, 0, 2'd1, 1, 32'd0, 32'h2400_0013);   // pc -> 0x3008

    // jal index 0xC10 at 0x3000, then a misaligned jr
    async_reset();
    drive(0, 0, 2'd0, 0, 32'd0, 32'h0C00_0C10);
    drive(0, 0, 2'd2, 0, 32'd0, 32'h2400_0021);   // pc -> 0x3040
    drive(0, 0, 2'd3, 0, 32'h0000_3021, 32'h2400_0022);
    drive(0, 0, 2'd0, 0, 32'd0, 32'h2400_0023);
    drive(0, 0, 2'd3, 0, 32'h0000_4000, 32'h2400_0024);

    // Stall three cycles with a taken beq in D, then release
    async_reset();
    drive(0, 0, 2'd0, 0, 32'd0, 32'h1000_0003);
    for (int i = 0; i < 3; i++) drive(0, 1, 2'd1, 1, 32'd0, $urandom);
    drive(0, 0, 2'd1, 1, 32'd0, 32'h2400_0031);
    drive(0, 0, 2'd0, 0, 32'd0, 32'h2400_0032);

    // Randomised traffic with occasional mid-run resets
    async_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 80) == 0) async_reset();
      else drive(0, ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
                 1'($urandom), $urandom, $urandom);
    end

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule : tb_fetch_npc_unit
`default_nettype wire
